ram_cart_arb: RTL and testbench
===============================

# ram_cart_arb

Two-port arbiter that shares the cart's 16-bit SRAM between the 68k cart bus and a background word port, such as MCU save-state or SD save/load DMA. The CPU always wins and sees zero added latency. Background accesses run in idle gaps, are aborted on CPU collision and are retried transparently. The block sits between the cart RAM mapper logic and the physical SRAM pins.

## Interface
Parameters:
- AW, 18, word address width.
- RD_WAIT, 2, SRAM access cycles per background op; legal range 2..15.

Ports:
- clk  in  1  mapper clock; all state updates on rising edge.
- map_rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access to the cart RAM area is active (level).
- cpu_oe  in  1  CPU read strobe, active high.
- cpu_we_lo / cpu_we_hi  in  1 each  CPU byte write strobes, active high.
- cpu_addr  in  AW  CPU word address.
- cpu_din  in  16  CPU write data.
- cpu_dout  out  16  mem_dout passthrough.
- bg_req  in  1  background request; held until bg_ack.
- bg_we  in  1  1 = write, 0 = read.
- bg_be  in  2  byte enables {hi, lo}.
- bg_addr  in  AW  background word address.
- bg_din  in  16  background write data.
- bg_dout  out  16  registered read data.
- bg_ack  out  1  one-cycle completion pulse.
- bg_err  out  1  one-cycle pulse; write rejected (see Configuration).
- abort_cnt  out  8  saturating count of aborted background ops.
- mem_addr  out  AW; mem_din  out  16; mem_dout  in  16.
- mem_ce, mem_oe, mem_we_lo, mem_we_hi  out  1 each.

## Operation
- States: IDLE, BG_ACC, BG_DONE; wait counter wcnt is 4 bits.
- CPU path is combinational.
  - While cpu_req=1: mem_addr=cpu_addr, mem_din=cpu_din, mem_ce=1, mem_oe=cpu_oe, mem_we_lo/hi=cpu_we_lo/hi.
  - This applies in every state.
- IDLE:
  - bg_req=1 and cpu_req=0 → BG_ACC, wcnt=0.
  - Otherwise stay in IDLE.
- BG_ACC (cpu_req=0): mem bus driven from bg_addr/bg_din, mem_ce=1.
  - Read: mem_oe=1.
  - Write: mem_oe=0; mem_we_lo=bg_be[0] and mem_we_hi=bg_be[1] while wcnt<RD_WAIT-1, deasserted on the final cycle for hold.
  - wcnt increments each cycle.
  - At wcnt=RD_WAIT-1: a read latches mem_dout into bg_dout; then → BG_DONE.
- BG_DONE: bg_ack=1 for one cycle → IDLE.
- Abort: cpu_req=1 while in BG_ACC.
  - CPU takes the bus that same cycle; background strobes drop combinationally.
  - State → IDLE; abort_cnt increments, saturating at 255.
  - No ack; bg_dout unchanged.
  - The op restarts from wcnt=0 once cpu_req=0. A partially written word is fully rewritten on retry.
- cpu_req rising in the same cycle the FSM would leave IDLE: CPU wins and the FSM stays in IDLE.
- cpu_req in BG_DONE: ack still issues; data is already latched.
- bg_req dropped before ack is illegal; behaviour is undefined.
- Idle defaults: with no owner, mem outputs = 0 and mem_addr = 0.

## Timing
- Reset values: state IDLE, wcnt 0, bg_dout 0, bg_ack 0, bg_err 0, abort_cnt 0.
- Reset values, mem outputs (cpu_req=0): mem_ce/oe/we_lo/we_hi 0, mem_addr 0, mem_din 0.
- Reset asserted mid-op: immediate return to reset values; no ack.
- CPU latency: 0 cycles (combinational).
- Background latency, uncontended: bg_req sampled high at edge N → bg_ack high during cycle N+RD_WAIT+1.
- Back-to-back: the next request is sampled no earlier than the edge after ack. Minimum period is RD_WAIT+2 cycles.
- bg_dout is valid from the ack cycle until the next completed read.

## Configuration
- RAM_ARB_BGWR_EN defined: background writes supported as above.
- RAM_ARB_BGWR_EN undefined:
  - bg_req with bg_we=1 in IDLE skips the memory access; mem strobes are never asserted.
  - Goes straight to BG_DONE; bg_ack and bg_err pulse together the cycle after sampling.
  - Reads are unaffected. bg_err is tied 0 when the macro is defined.

## Test plan
- Reset, then bg read of addr 0x00010 (mem returns 0xA55A), RD_WAIT=2 → bg_ack 3 cycles after sample; bg_dout=0xA55A; mem_we never high.
- bg write 0x1234 to 0x00020 with bg_be=2'b01 → only mem_we_lo high for 1 cycle; mem_din=0x1234; ack 3 cycles after sample.
- cpu_req asserted in the 2nd BG_ACC cycle of a write → mem_addr=cpu_addr that cycle; no ack; abort_cnt=1; op retries after cpu_req drops, and ack follows RD_WAIT+1 cycles later.
- 300 forced aborts → abort_cnt saturates at 255.
- cpu_req and bg_req rise in the same cycle → CPU drives the bus; FSM stays in IDLE; bg ack comes RD_WAIT+1 cycles after cpu_req falls.
- Macro undefined, bg write request → bg_ack and bg_err pulse together the next cycle; mem_we_lo/hi stay 0; map_rst_n low mid-read clears state with no ack.

Source files
------------

// File: rtl/ram_cart_arb.sv
// ram_cart_arb: shares the cart 16-bit SRAM between the 68k cart bus and a
// background word port (save-state / SD DMA).  The CPU path is purely
// combinational and always wins; background accesses run in idle gaps, are
// dropped the instant the CPU shows up and are retried from scratch.
//
// Build option: define RAM_ARB_BGWR_EN to allow background writes.  Without
// it a background write never touches the SRAM and completes at once with
// bg_ack and bg_err pulsing together.
//
// RD_WAIT must be in 2..15 so the final access cycle fits the 4-bit counter.
module ram_cart_arb #(
   parameter int AW      = 18,
   parameter int RD_WAIT = 2
) (
   input  logic          clk,
   input  logic          map_rst_n,
   // 68k cart bus side
   input  logic          cpu_req,
   input  logic          cpu_oe,
   input  logic          cpu_we_lo,
   input  logic          cpu_we_hi,
   input  logic [AW-1:0] cpu_addr,
   input  logic [15:0]   cpu_din,
   output logic [15:0]   cpu_dout,
   // background word port
   input  logic          bg_req,
   input  logic          bg_we,
   input  logic [1:0]    bg_be,
   input  logic [AW-1:0] bg_addr,
   input  logic [15:0]   bg_din,
   output logic [15:0]   bg_dout,
   output logic          bg_ack,
   output logic          bg_err,
   output logic [7:0]    abort_cnt,
   // SRAM pins
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_din,
   input  logic [15:0]   mem_dout,
   output logic          mem_ce,
   output logic          mem_oe,
   output logic          mem_we_lo,
   output logic          mem_we_hi
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BG_ACC  = 2'd1,
      BG_DONE = 2'd2
   } state_t;

   // index of the final access cycle; strobes drop here so data is held
   localparam logic [3:0] LAST_WCNT = 4'(RD_WAIT - 1);

   state_t        r_state;
   state_t        w_state_next;
   logic [3:0]    r_wcnt;
   logic [3:0]    w_wcnt_next;
   logic [15:0]   r_bg_dout;
   logic          r_bg_ack;
   logic [7:0]    r_abort_cnt;

   logic          w_start;      // IDLE samples a request with the bus free
   logic          w_bg_rej;     // request is a write that this build refuses
   logic          w_bg_wr;      // background op is a write that goes to SRAM
   logic          w_last;       // current access cycle is the final one
   logic          w_abort;      // CPU collided with an access in progress
   logic          w_latch;      // read data is captured this cycle

`ifdef RAM_ARB_BGWR_EN
   localparam logic BGWR_EN = 1'b1;

   assign w_bg_rej = 1'b0;
   assign bg_err   = 1'b0;
`else
   localparam logic BGWR_EN = 1'b0;

   logic r_bg_err;

   assign w_bg_rej = bg_we;

   // flag a refused write in the same cycle its ack goes out
   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n)
         r_bg_err <= 1'b0;
      else
         r_bg_err <= w_start && w_bg_rej;
   end

   assign bg_err = r_bg_err;
`endif

   assign w_start = (r_state == IDLE) && bg_req && !cpu_req;
   assign w_bg_wr = BGWR_EN && bg_we;
   assign w_last  = (r_wcnt == LAST_WCNT);
   assign w_abort = (r_state == BG_ACC) && cpu_req;
   assign w_latch = (r_state == BG_ACC) && !cpu_req && w_last && !bg_we;

   // next-state logic: CPU activity always blocks or cancels background work
   always_comb begin
      w_state_next = r_state;
      w_wcnt_next  = r_wcnt;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_wcnt_next = 4'd0;
               if (w_bg_rej)
                  w_state_next = BG_DONE;
               else
                  w_state_next = BG_ACC;
            end
         end
         BG_ACC: begin
            if (cpu_req) begin
               // abandon; the op restarts from zero once the CPU leaves
               w_state_next = IDLE;
               w_wcnt_next  = 4'd0;
            end else if (w_last) begin
               w_state_next = BG_DONE;
               w_wcnt_next  = 4'd0;
            end else begin
               w_wcnt_next  = r_wcnt + 4'd1;
            end
         end
         BG_DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
            w_wcnt_next  = 4'd0;
         end
      endcase
   end

   // state and access-cycle counter
   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n) begin
         r_state <= IDLE;
         r_wcnt  <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_wcnt  <= w_wcnt_next;
      end
   end

   // ack is high exactly while the FSM sits in BG_DONE
   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n)
         r_bg_ack <= 1'b0;
      else
         r_bg_ack <= (w_state_next == BG_DONE);
   end

   // read data capture on the final uncontended access cycle
   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n)
         r_bg_dout <= 16'd0;
      else if (w_latch)
         r_bg_dout <= mem_dout;
   end

   // saturating collision counter
   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n)
         r_abort_cnt <= 8'd0;
      else if (w_abort && (r_abort_cnt != 8'hFF))
         r_abort_cnt <= r_abort_cnt + 8'd1;
   end

   // SRAM bus mux: CPU first, then an active background access, else parked
   always_comb begin
      mem_addr  = '0;
      mem_din   = 16'd0;
      mem_ce    = 1'b0;
      mem_oe    = 1'b0;
      mem_we_lo = 1'b0;
      mem_we_hi = 1'b0;
      if (cpu_req) begin
         mem_addr  = cpu_addr;
         mem_din   = cpu_din;
         mem_ce    = 1'b1;
         mem_oe    = cpu_oe;
         mem_we_lo = cpu_we_lo;
         mem_we_hi = cpu_we_hi;
      end else if (r_state == BG_ACC) begin
         mem_addr  = bg_addr;
         mem_din   = bg_din;
         mem_ce    = 1'b1;
         mem_oe    = !bg_we;
         mem_we_lo = w_bg_wr && bg_be[0] && !w_last;
         mem_we_hi = w_bg_wr && bg_be[1] && !w_last;
      end
   end

   assign cpu_dout  = mem_dout;
   assign bg_dout   = r_bg_dout;
   assign bg_ack    = r_bg_ack;
   assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_ram_cart_arb.sv
// tb_ram_cart_arb: directed bench for ram_cart_arb with a cycle-count
// reference model and a small SRAM stub.  Honours RAM_ARB_BGWR_EN the same
// way the design does.
module tb_ram_cart_arb;

   localparam int AW = 18;
   localparam int RW = 2;
`ifdef RAM_ARB_BGWR_EN
   localparam bit WR_EN = 1'b1;
`else
   localparam bit WR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          cpu_req, cpu_oe, cpu_we_lo, cpu_we_hi;
   logic [AW-1:0] cpu_addr;
   logic [15:0]   cpu_din, cpu_dout;
   logic          bg_req, bg_we;
   logic [1:0]    bg_be;
   logic [AW-1:0] bg_addr;
   logic [15:0]   bg_din, bg_dout;
   logic          bg_ack, bg_err;
   logic [7:0]    abort_cnt;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_din, mem_dout;
   logic          mem_ce, mem_oe, mem_we_lo, mem_we_hi;

   int checks = 0;
   int errors = 0;

   ram_cart_arb #(.AW(AW), .RD_WAIT(RW)) dut (
      .clk(clk), .map_rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_oe(cpu_oe), .cpu_we_lo(cpu_we_lo), .cpu_we_hi(cpu_we_hi),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .bg_req(bg_req), .bg_we(bg_we), .bg_be(bg_be), .bg_addr(bg_addr), .bg_din(bg_din),
      .bg_dout(bg_dout), .bg_ack(bg_ack), .bg_err(bg_err), .abort_cnt(abort_cnt),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM stub: word i holds {i, ~i} after reset, except 0x10 = 0xA55A
   logic [15:0] sram [256];
   assign mem_dout = sram[mem_addr[7:0]];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) sram[i] <= {i[7:0], ~i[7:0]};
         sram[8'h10] <= 16'hA55A;
      end else begin
         if (mem_ce && mem_we_lo) sram[mem_addr[7:0]][7:0]  <= mem_din[7:0];
         if (mem_ce && mem_we_hi) sram[mem_addr[7:0]][15:8] <= mem_din[15:8];
      end
   end

   // reference model: m_acc = uncontended access cycles already spent on the
   // current op (-1 = no access running); m_ack/m_err = completion this cycle
   int          m_acc;
   bit          m_ack, m_err;
   logic [15:0] m_dout;
   int          m_abort;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_acc <= -1; m_ack <= 0; m_err <= 0; m_dout <= 16'd0; m_abort <= 0;
      end else begin
         m_ack <= 0;
         m_err <= 0;
         if (m_acc >= 0) begin
            if (cpu_req) begin
               m_acc <= -1;
               if (m_abort < 255) m_abort <= m_abort + 1;
            end else if (m_acc == RW - 1) begin
               if (!bg_we) m_dout <= sram[bg_addr[7:0]];
               m_acc <= -1;
               m_ack <= 1;
            end else begin
               m_acc <= m_acc + 1;
            end
         end else if (!m_ack && bg_req && !cpu_req) begin
            if (bg_we && !WR_EN) begin
               m_ack <= 1;
               m_err <= 1;
            end else begin
               m_acc <= 0;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-cycle comparison of every output against the model
   logic [AW-1:0] e_addr;
   logic [15:0]   e_din;
   logic          e_ce, e_oe, e_wl, e_wh;

   always @(negedge clk) begin
      e_addr = '0; e_din = 16'd0; e_ce = 0; e_oe = 0; e_wl = 0; e_wh = 0;
      if (cpu_req) begin
         e_addr = cpu_addr; e_din = cpu_din; e_ce = 1; e_oe = cpu_oe;
         e_wl = cpu_we_lo; e_wh = cpu_we_hi;
      end else if (m_acc >= 0) begin
         e_addr = bg_addr; e_din = bg_din; e_ce = 1; e_oe = !bg_we;
         e_wl = WR_EN && bg_we && bg_be[0] && (m_acc < RW - 1);
         e_wh = WR_EN && bg_we && bg_be[1] && (m_acc < RW - 1);
      end
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_din", 32'(mem_din), 32'(e_din));
      chk("mem_ce", 32'(mem_ce), 32'(e_ce));
      chk("mem_oe", 32'(mem_oe), 32'(e_oe));
      chk("mem_we_lo", 32'(mem_we_lo), 32'(e_wl));
      chk("mem_we_hi", 32'(mem_we_hi), 32'(e_wh));
      chk("bg_ack", 32'(bg_ack), 32'(m_ack));
      chk("bg_err", 32'(bg_err), 32'(m_err));
      chk("bg_dout", 32'(bg_dout), 32'(m_dout));
      chk("abort_cnt", 32'(abort_cnt), 32'(m_abort));
      chk("cpu_dout", 32'(cpu_dout), 32'(mem_dout));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // counts edges from issue to the cycle bg_ack is seen; n = -1 on timeout
   task automatic wait_ack(output int n, output bit err_seen, output int wl, output int wh);
      n = 0; err_seen = 0; wl = 0; wh = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (mem_we_lo) wl++;
         if (mem_we_hi) wh++;
         if (bg_ack) begin
            err_seen = bg_err;
            return;
         end
      end
      n = -1;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [15:0] exp, input string nm);
      int n, wl, wh;
      bit e;
      bg_addr = a; bg_we = 0; bg_be = 2'b11; bg_req = 1;
      wait_ack(n, e, wl, wh);
      $display("txn %s read addr %05h lat %0d data %04h", nm, a, n, bg_dout);
      chk({nm, "_lat"}, 32'(n), 32'(RW + 1));
      chk({nm, "_data"}, 32'(bg_dout), 32'(exp));
      chk({nm, "_we"}, 32'(wl + wh), 32'd0);
      chk({nm, "_err"}, 32'(e), 32'd0);
      tick();
      bg_req = 0;
   endtask

   initial begin
      int n, wl, wh;
      bit e;
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, wl, wh;
      bit e;
      rst_n = 0; cpu_req = 0; cpu_oe = 0; cpu_we_lo = 0; cpu_we_hi = 0;
      cpu_addr = '0; cpu_din = 16'd0;
      bg_req = 0; bg_we = 0; bg_be = 2'b00; bg_addr = '0; bg_din = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", 32'(bg_ack), 32'd0);
      chk("rst_dout", 32'(bg_dout), 32'd0);
      chk("rst_abort", 32'(abort_cnt), 32'd0);
      chk("rst_ce", 32'(mem_ce), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      rst_n = 1;
      tick();

      // plain read
      do_read(18'h00010, 16'hA55A, "rd10");

      // background write, low byte only
      bg_addr = 18'h00020; bg_we = 1; bg_be = 2'b01; bg_din = 16'h1234; bg_req = 1;
      wait_ack(n, e, wl, wh);
      $display("txn write addr 00020 lat %0d err %0d we_lo %0d we_hi %0d", n, e, wl, wh);
`ifdef RAM_ARB_BGWR_EN
      chk("wr_lat", 32'(n), 32'd3);
      chk("wr_err", 32'(e), 32'd0);
      chk("wr_we_lo", 32'(wl), 32'd1);
      chk("wr_we_hi", 32'(wh), 32'd0);
`else
      chk("wr_lat", 32'(n), 32'd1);
      chk("wr_err", 32'(e), 32'd1);
      chk("wr_we_lo", 32'(wl), 32'd0);
      chk("wr_we_hi", 32'(wh), 32'd0);
`endif
      tick();
      bg_req = 0;
`ifdef RAM_ARB_BGWR_EN
      do_read(18'h00020, 16'h2034, "rd20");
`else
      do_read(18'h00020, 16'h20DF, "rd20");
`endif

      // CPU collides in the second access cycle
      bg_addr = 18'h00030; bg_din = 16'hBEEF; bg_be = 2'b11; bg_we = WR_EN; bg_req = 1;
      tick();
      tick();
      cpu_req = 1; cpu_oe = 1; cpu_addr = 18'h2ABCD;
      @(negedge clk);
      chk("abort_addr", 32'(mem_addr), 32'h2ABCD);
      chk("abort_noack", 32'(bg_ack), 32'd0);
      tick();
      tick();
      cpu_req = 0; cpu_oe = 0;
      chk("abort_cnt1", 32'(abort_cnt), 32'd1);
      wait_ack(n, e, wl, wh);
      $display("txn abort-retry addr 00030 lat %0d abort_cnt %0d", n, abort_cnt);
      chk("retry_lat", 32'(n), 32'd3);
`ifndef RAM_ARB_BGWR_EN
      chk("retry_data", 32'(bg_dout), 32'h30CF);
`endif
      tick();
      bg_req = 0;
`ifdef RAM_ARB_BGWR_EN
      do_read(18'h00030, 16'hBEEF, "rd30");
`endif

      // CPU and background request rise together
      cpu_req = 1; cpu_oe = 1; cpu_addr = 18'h11111;
      bg_addr = 18'h00010; bg_we = 0; bg_be = 2'b11; bg_req = 1;
      tick();
      tick();
      cpu_req = 0; cpu_oe = 0;
      chk("coll_abort", 32'(abort_cnt), 32'd1);
      wait_ack(n, e, wl, wh);
      $display("txn collide read addr 00010 lat %0d data %04h", n, bg_dout);
      chk("coll_lat", 32'(n), 32'd3);
      chk("coll_data", 32'(bg_dout), 32'hA55A);
      tick();
      bg_req = 0;

      // 300 forced aborts
      bg_addr = 18'h00011; bg_we = 0; bg_req = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         cpu_req = 1; cpu_addr = 18'h00099;
         tick();
         cpu_req = 0;
      end
      $display("txn saturate aborts 300 abort_cnt %0d", abort_cnt);
      chk("sat_cnt", 32'(abort_cnt), 32'd255);
      wait_ack(n, e, wl, wh);
      chk("sat_lat", 32'(n), 32'd3);
      chk("sat_data", 32'(bg_dout), 32'h11EE);
      tick();
      bg_req = 0;

      // reset mid-read
      bg_addr = 18'h00040; bg_we = 0; bg_req = 1;
      tick();
      #2;
      rst_n = 0;
      #1;
      $display("txn reset mid-read ack %0d abort_cnt %0d", bg_ack, abort_cnt);
      chk("mrst_ack", 32'(bg_ack), 32'd0);
      chk("mrst_abort", 32'(abort_cnt), 32'd0);
      chk("mrst_dout", 32'(bg_dout), 32'd0);
      chk("mrst_ce", 32'(mem_ce), 32'd0);
      bg_req = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      tick();
      do_read(18'h00040, 16'h40BF, "rd40");

      // CPU high-byte write, then read it back through the background port
      cpu_req = 1; cpu_we_hi = 1; cpu_addr = 18'h00050; cpu_din = 16'hCAFE;
      tick();
      cpu_req = 0; cpu_we_hi = 0;
      $display("txn cpu write addr 00050 hi byte ca");
      do_read(18'h00050, 16'hCAAF, "rd50");

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
